// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared definitions for the data-memory arbiter:
//   - arb_state_e          : arbiter FSM states
//   - DEFAULT_BASE_ADDR    : byte address that maps to memory word 0
//   - starve_cnt_width()   : width of the EXT starvation counter
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        CPU_ACCESS = 3'd1,
        CPU_RESP   = 3'd2,
        EXT_ACCESS = 3'd3,
        EXT_RESP   = 3'd4
    } arb_state_e;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0000;

    // Enough bits to hold the value STARVE_LIMIT itself (the saturation point).
    function automatic int starve_cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/dmem_addr_xlate.sv
// -----------------------------------------------------------------------------
// dmem_addr_xlate
// Combinational byte-address to word-index translation.
//   offset     = i_addr - BASE_ADDR (mod 2^NBits)
//   o_word_idx = offset >> 2 (byte lane bits ignored)
//   o_err      = offset out of range or misaligned, only when
//                DMEM_ARB_ADDR_CHECK_EN is defined; constant 0 otherwise.
// Ports:
//   i_addr      in  NBits  byte address
//   o_word_idx  out NBits  word index into the data memory
//   o_err       out 1      address error flag
// -----------------------------------------------------------------------------
module dmem_addr_xlate
    import dmem_arb_pkg::*;
#(
    parameter int                NBits        = 32,
    parameter int                MEMORY_DEPTH = 64,
    parameter logic [NBits-1:0]  BASE_ADDR    = NBits'(DEFAULT_BASE_ADDR)
) (
    input  logic [NBits-1:0] i_addr,
    output logic [NBits-1:0] o_word_idx,
    output logic             o_err
);

    localparam logic [NBits-1:0] BYTE_SPAN = NBits'(MEMORY_DEPTH * 4);

    logic [NBits-1:0] w_offset;
    logic             w_flag;
    logic             w_unused;

    // Wrap-around subtraction: an address below BASE_ADDR becomes a huge
    // offset, so a single upper-bound compare covers both ends of the window.
    assign w_offset   = i_addr - BASE_ADDR;
    assign o_word_idx = {2'b00, w_offset[NBits-1:2]};
    assign w_flag     = (w_offset >= BYTE_SPAN) || (i_addr[1:0] != 2'b00);

`ifdef DMEM_ARB_ADDR_CHECK_EN
    assign o_err    = w_flag;
    assign w_unused = ^w_offset[1:0];
`else
    assign o_err    = 1'b0;
    assign w_unused = ^{w_offset[1:0], w_flag};
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares one single-port data memory between the pipeline MEM stage (CPU)
// and an external loader/debug port (EXT). Every access takes three cycles:
// arbitrate (IDLE) -> ACCESS (memory strobes high) -> RESP (result visible).
// CPU wins ties unless EXT has lost STARVE_LIMIT consecutive arbitrations.
//
// Optional feature: define DMEM_ARB_ADDR_CHECK_EN to flag out-of-range or
// misaligned accesses (strobes suppressed, read data forced to 0, addr_err
// pulses in RESP). Without it addresses wrap and addr_err is constant 0.
//
// Ports:
//   clk, reset                     clock (rising edge), async active-low reset
//   cpu_req/we/addr/wdata    in    MEM-stage request
//   cpu_rdata                out   CPU load data, held until next CPU read
//   cpu_stall                out   cpu_req && state != CPU_RESP
//   ext_req/we/addr/wdata    in    EXT request (held until ext_ack)
//   ext_rdata                out   EXT load data
//   ext_ack                  out   one-cycle completion pulse
//   mem_addr/wdata/we/re     out   registered memory interface (word index)
//   mem_rdata                in    combinational memory read data
//   addr_err                 out   one-cycle address error pulse
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int                NBits        = 32,
    parameter int                MEMORY_DEPTH = 64,
    parameter logic [NBits-1:0]  BASE_ADDR    = NBits'(DEFAULT_BASE_ADDR),
    parameter int                STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [NBits-1:0] cpu_addr,
    input  logic [NBits-1:0] cpu_wdata,
    output logic [NBits-1:0] cpu_rdata,
    output logic             cpu_stall,
    input  logic             ext_req,
    input  logic             ext_we,
    input  logic [NBits-1:0] ext_addr,
    input  logic [NBits-1:0] ext_wdata,
    output logic [NBits-1:0] ext_rdata,
    output logic             ext_ack,
    output logic [NBits-1:0] mem_addr,
    output logic [NBits-1:0] mem_wdata,
    output logic             mem_we,
    output logic             mem_re,
    input  logic [NBits-1:0] mem_rdata,
    output logic             addr_err
);

    localparam int             SCW        = starve_cnt_width(STARVE_LIMIT);
    localparam logic [SCW-1:0] STARVE_MAX = SCW'(STARVE_LIMIT);

    arb_state_e       r_state;
    arb_state_e       w_next_state;
    logic [SCW-1:0]   r_starve_cnt;

    logic [NBits-1:0] r_mem_addr;
    logic [NBits-1:0] r_mem_wdata;
    logic             r_mem_we;
    logic             r_mem_re;
    logic             r_we;
    logic             r_err;
    logic [NBits-1:0] r_cpu_rdata;
    logic [NBits-1:0] r_ext_rdata;

    logic             w_ext_wins;
    logic             w_any_req;
    logic             w_sel_we;
    logic [NBits-1:0] w_sel_addr;
    logic [NBits-1:0] w_sel_wdata;
    logic [NBits-1:0] w_word_idx;
    logic             w_err;

    // EXT takes the grant when CPU is idle or when EXT has been starved.
    assign w_ext_wins  = ext_req && (!cpu_req || (r_starve_cnt == STARVE_MAX));
    assign w_any_req   = cpu_req || ext_req;
    assign w_sel_we    = w_ext_wins ? ext_we    : cpu_we;
    assign w_sel_addr  = w_ext_wins ? ext_addr  : cpu_addr;
    assign w_sel_wdata = w_ext_wins ? ext_wdata : cpu_wdata;

    // Only the winner's address is ever used, so one translator suffices.
    dmem_addr_xlate #(
        .NBits        (NBits),
        .MEMORY_DEPTH (MEMORY_DEPTH),
        .BASE_ADDR    (BASE_ADDR)
    ) u_xlate (
        .i_addr     (w_sel_addr),
        .o_word_idx (w_word_idx),
        .o_err      (w_err)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    // NOTE: the default assignment first guarantees no latch is inferred for
    // paths that do not change state.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_ext_wins)   w_next_state = EXT_ACCESS;
                else if (cpu_req) w_next_state = CPU_ACCESS;
            end
            CPU_ACCESS: w_next_state = CPU_RESP;
            CPU_RESP:   w_next_state = IDLE;
            EXT_ACCESS: w_next_state = EXT_RESP;
            EXT_RESP:   w_next_state = IDLE;
            default:    w_next_state = IDLE;
        endcase
    end

    // Datapath: the access registers double as the registered mem_* outputs,
    // loaded at the arbitration edge so strobes are high during ACCESS only.
    // An asynchronous reset clears mem_we at once, so no write can land after
    // reset asserts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_starve_cnt <= '0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_we     <= 1'b0;
            r_mem_re     <= 1'b0;
            r_we         <= 1'b0;
            r_err        <= 1'b0;
            r_cpu_rdata  <= '0;
            r_ext_rdata  <= '0;
        end else begin
            r_mem_we <= 1'b0;
            r_mem_re <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_mem_addr  <= w_word_idx;
                        r_mem_wdata <= w_sel_wdata;
                        r_mem_we    <= w_sel_we && !w_err;
                        r_mem_re    <= !w_sel_we && !w_err;
                        r_we        <= w_sel_we;
                        r_err       <= w_err;
                    end
                    if (w_ext_wins || !ext_req)
                        r_starve_cnt <= '0;
                    else if (r_starve_cnt != STARVE_MAX)
                        r_starve_cnt <= r_starve_cnt + SCW'(1);
                end
                CPU_ACCESS: begin
                    if (!r_we) r_cpu_rdata <= r_err ? '0 : mem_rdata;
                end
                EXT_ACCESS: begin
                    if (!r_we) r_ext_rdata <= r_err ? '0 : mem_rdata;
                end
                default: ;
            endcase
        end
    end

    assign cpu_rdata = r_cpu_rdata;
    assign ext_rdata = r_ext_rdata;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_we    = r_mem_we;
    assign mem_re    = r_mem_re;
    assign cpu_stall = cpu_req && (r_state != CPU_RESP);
    assign ext_ack   = (r_state == EXT_RESP);

`ifdef DMEM_ARB_ADDR_CHECK_EN
    assign addr_err  = r_err && ((r_state == CPU_RESP) || (r_state == EXT_RESP));
`else
    assign addr_err  = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed self-checking bench for dmem_arbiter. Owns a 64-word memory model
// (synchronous write, combinational read) with a backdoor preload port.
// Inputs are driven 1 ns after the rising edge, outputs sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        ext_req, ext_we;
    logic [31:0] ext_addr, ext_wdata, ext_rdata;
    logic        ext_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we, mem_re;
    logic        addr_err;

    logic [31:0] mem [0:63];
    logic        tb_we;
    logic [5:0]  tb_idx;
    logic [31:0] tb_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we)     mem[mem_addr[5:0]] <= mem_wdata;
        else if (tb_we) mem[tb_idx]        <= tb_data;
    end
    assign mem_rdata = mem[mem_addr[5:0]];

    dmem_arbiter #(
        .NBits        (32),
        .MEMORY_DEPTH (64),
        .BASE_ADDR    (32'h1001_0000),
        .STARVE_LIMIT (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .ext_req   (ext_req),
        .ext_we    (ext_we),
        .ext_addr  (ext_addr),
        .ext_wdata (ext_wdata),
        .ext_rdata (ext_rdata),
        .ext_ack   (ext_ack),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .addr_err  (addr_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [5:0] idx, input logic [31:0] data);
        tb_idx  = idx;
        tb_data = data;
        tb_we   = 1'b1;
        tick();
        tb_we   = 1'b0;
    endtask

    task automatic test_reset();
        n_tests++;
        if ({cpu_rdata, ext_rdata} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_rdata: cpu=%h ext=%h want 0", cpu_rdata, ext_rdata);
        end
        n_tests++;
        if ({ext_ack, addr_err, mem_we, mem_re, cpu_stall} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: ack/err/we/re/stall=%b want 00000",
                     {ext_ack, addr_err, mem_we, mem_re, cpu_stall});
        end
        n_tests++;
        if ({mem_addr, mem_wdata} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_mem_bus: addr=%h wdata=%h want 0", mem_addr, mem_wdata);
        end
    endtask

    task automatic test_cpu_read();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h1001_0008;
        @(negedge clk);
        n_tests++;
        if (cpu_stall !== 1'b1 || mem_re !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_cycleN: stall=%b re=%b want 1/0", cpu_stall, mem_re);
        end
        tick();
        @(negedge clk);
        n_tests++;
        if (mem_addr !== 32'd2 || mem_re !== 1'b1 || mem_we !== 1'b0 || cpu_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL rd_access: addr=%0d re=%b we=%b stall=%b want 2/1/0/1",
                     mem_addr, mem_re, mem_we, cpu_stall);
        end
        tick();
        @(negedge clk);
        n_tests++;
        if (cpu_stall !== 1'b0 || cpu_rdata !== 32'hDEAD_BEEF || mem_re !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_resp: stall=%b rdata=%h re=%b want 0/deadbeef/0",
                     cpu_stall, cpu_rdata, mem_re);
        end
        cpu_req = 1'b0;
        tick();
    endtask

    task automatic test_cpu_write();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h1001_0010; cpu_wdata = 32'h1234_5678;
        @(negedge clk);
        n_tests++;
        if (mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_cycleN_we: got %b want 0", mem_we);
        end
        tick();
        @(negedge clk);
        n_tests++;
        if (mem_we !== 1'b1 || mem_re !== 1'b0 || mem_addr !== 32'd4 || mem_wdata !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL wr_access: we=%b re=%b addr=%0d wdata=%h want 1/0/4/12345678",
                     mem_we, mem_re, mem_addr, mem_wdata);
        end
        tick();
        @(negedge clk);
        n_tests++;
        if (mem_we !== 1'b0 || cpu_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_resp: we=%b stall=%b want 0/0", mem_we, cpu_stall);
        end
        cpu_req = 1'b0; cpu_we = 1'b0;
        tick();
        n_tests++;
        if (mem[4] !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL wr_mem_word4: got %h want 12345678", mem[4]);
        end
        cpu_req = 1'b1; cpu_addr = 32'h1001_0010;
        tick();
        tick();
        @(negedge clk);
        n_tests++;
        if (cpu_rdata !== 32'h1234_5678 || cpu_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_readback: rdata=%h stall=%b want 12345678/0", cpu_rdata, cpu_stall);
        end
        cpu_req = 1'b0;
        tick();
    endtask

    task automatic test_ext_write();
        ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h1001_0018; ext_wdata = 32'hCAFE_0001;
        @(negedge clk);
        n_tests++;
        if (ext_ack !== 1'b0 || cpu_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL extwr_cycleN: ack=%b stall=%b want 0/0", ext_ack, cpu_stall);
        end
        tick();
        @(negedge clk);
        n_tests++;
        if (mem_we !== 1'b1 || mem_addr !== 32'd6 || ext_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL extwr_access: we=%b addr=%0d ack=%b want 1/6/0", mem_we, mem_addr, ext_ack);
        end
        tick();
        @(negedge clk);
        n_tests++;
        if (ext_ack !== 1'b1 || mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL extwr_resp: ack=%b we=%b want 1/0", ext_ack, mem_we);
        end
        ext_req = 1'b0; ext_we = 1'b0;
        tick();
        @(negedge clk);
        n_tests++;
        if (ext_ack !== 1'b0 || mem[6] !== 32'hCAFE_0001) begin
            n_fail++;
            $display("FAIL extwr_after: ack=%b word6=%h want 0/cafe0001", ext_ack, mem[6]);
        end
        tick();
    endtask

    task automatic test_starvation();
        int acks = 0;
        int cpu_done = 0;
        int cpu_before = -1;
        int cpu_between = -1;
        logic [31:0] ext_rd_at_ack = 32'h0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h1001_0008;
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h1001_000C;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (ext_ack === 1'b1) begin
                acks++;
                if (acks == 1) begin
                    cpu_before    = cpu_done;
                    ext_rd_at_ack = ext_rdata;
                end else if (acks == 2) begin
                    cpu_between = cpu_done - cpu_before;
                end
            end
            if (cpu_stall === 1'b0) cpu_done++;
            if (i == 29) begin
                cpu_req = 1'b0;
                ext_req = 1'b0;
            end else begin
                tick();
            end
        end
        n_tests++;
        if (cpu_before !== 4) begin
            n_fail++;
            $display("FAIL starve_first_round: cpu grants=%0d want 4", cpu_before);
        end
        n_tests++;
        if (cpu_between !== 4) begin
            n_fail++;
            $display("FAIL starve_cleared: cpu grants after ext=%0d want 4", cpu_between);
        end
        n_tests++;
        if (acks !== 2) begin
            n_fail++;
            $display("FAIL starve_ack_cycles: got %0d want 2", acks);
        end
        n_tests++;
        if (ext_rd_at_ack !== 32'h3333_3333) begin
            n_fail++;
            $display("FAIL starve_ext_rdata: got %h want 33333333", ext_rd_at_ack);
        end
        tick();
    endtask

    task automatic test_reset_mid_write();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h1001_0014; cpu_wdata = 32'hAAAA_AAAA;
        tick();
        n_tests++;
        if (mem_we !== 1'b1 || mem_addr !== 32'd5) begin
            n_fail++;
            $display("FAIL rst_pre_we: we=%b addr=%0d want 1/5", mem_we, mem_addr);
        end
        #1 reset = 1'b0;
        #1;
        n_tests++;
        if (mem_we !== 1'b0 || mem_re !== 1'b0 || cpu_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_immediate: we=%b re=%b stall=%b want 0/0/1", mem_we, mem_re, cpu_stall);
        end
        cpu_req = 1'b0; cpu_we = 1'b0;
        #1;
        n_tests++;
        if (cpu_stall !== 1'b0 || cpu_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_outputs: stall=%b rdata=%h want 0/0", cpu_stall, cpu_rdata);
        end
        tick();
        n_tests++;
        if (mem[5] !== 32'h5555_5555) begin
            n_fail++;
            $display("FAIL rst_word5: got %h want 55555555", mem[5]);
        end
        reset = 1'b1;
        tick();
        cpu_req = 1'b1; cpu_addr = 32'h1001_0014;
        tick();
        tick();
        @(negedge clk);
        n_tests++;
        if (cpu_stall !== 1'b0 || cpu_rdata !== 32'h5555_5555) begin
            n_fail++;
            $display("FAIL rst_recover_read: stall=%b rdata=%h want 0/55555555", cpu_stall, cpu_rdata);
        end
        cpu_req = 1'b0;
        tick();
    endtask

`ifdef DMEM_ARB_ADDR_CHECK_EN
    task automatic test_addr_check();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h1001_0100; cpu_wdata = 32'h7777_7777;
        tick();
        @(negedge clk);
        n_tests++;
        if (mem_we !== 1'b0 || mem_re !== 1'b0 || addr_err !== 1'b0) begin
            n_fail++;
            $display("FAIL chk_wr_access: we=%b re=%b err=%b want 0/0/0", mem_we, mem_re, addr_err);
        end
        tick();
        @(negedge clk);
        n_tests++;
        if (addr_err !== 1'b1 || cpu_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL chk_wr_resp: err=%b stall=%b want 1/0", addr_err, cpu_stall);
        end
        cpu_req = 1'b0; cpu_we = 1'b0;
        tick();
        @(negedge clk);
        n_tests++;
        if (addr_err !== 1'b0) begin
            n_fail++;
            $display("FAIL chk_err_pulse: got %b want 0", addr_err);
        end
        tick();
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h1001_0002;
        tick();
        @(negedge clk);
        n_tests++;
        if (mem_re !== 1'b0 || mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL chk_ext_access: re=%b we=%b want 0/0", mem_re, mem_we);
        end
        tick();
        @(negedge clk);
        n_tests++;
        if (ext_ack !== 1'b1 || addr_err !== 1'b1 || ext_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL chk_ext_resp: ack=%b err=%b rdata=%h want 1/1/0", ext_ack, addr_err, ext_rdata);
        end
        ext_req = 1'b0;
        tick();
    endtask
`else
    task automatic test_addr_wrap();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h1001_0100;
        tick();
        @(negedge clk);
        n_tests++;
        if (mem_addr !== 32'd64 || mem_re !== 1'b1 || addr_err !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_access: addr=%0d re=%b err=%b want 64/1/0", mem_addr, mem_re, addr_err);
        end
        tick();
        @(negedge clk);
        n_tests++;
        if (addr_err !== 1'b0 || cpu_rdata !== 32'h0BAD_F00D || cpu_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_resp: err=%b rdata=%h stall=%b want 0/0badf00d/0",
                     addr_err, cpu_rdata, cpu_stall);
        end
        cpu_req = 1'b0;
        tick();
    endtask
`endif

    initial begin
        reset     = 1'b0;
        cpu_req   = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        ext_req   = 1'b0; ext_we = 1'b0; ext_addr = 32'h0; ext_wdata = 32'h0;
        tb_we     = 1'b0; tb_idx = 6'd0; tb_data = 32'h0;
        tick();
        preload(6'd0, 32'h0BAD_F00D);
        preload(6'd2, 32'hDEAD_BEEF);
        preload(6'd3, 32'h3333_3333);
        preload(6'd5, 32'h5555_5555);
        test_reset();
        #2 reset = 1'b1;
        tick();
        test_cpu_read();
        test_cpu_write();
        test_ext_write();
        test_starvation();
        test_reset_mid_write();
`ifdef DMEM_ARB_ADDR_CHECK_EN
        test_addr_check();
`else
        test_addr_wrap();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

- Shares the single-port data memory between two requesters: the pipeline MEM stage (CPU) and an external loader/debug port (EXT).
- Sits between the MEM-stage control signals and the data memory.
- Performs base-address translation, fixed-priority arbitration with starvation escape, and registered request/response sequencing.
- Stalls the pipeline while a CPU access is in flight.

## Interface
Parameters:
- NBits, 32, data/address width
- MEMORY_DEPTH, 64, memory size in words
- BASE_ADDR, 32'h1001_0000, byte address mapped to word 0
- STARVE_LIMIT, 4, consecutive lost arbitrations before EXT is forced to win

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- cpu_req  in  1  MEM stage access request; equals MemRead|MemWrite
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  NBits  byte address (ALU result)
- cpu_wdata  in  NBits  store data
- cpu_rdata  out  NBits  load data; holds until the next CPU read completes
- cpu_stall  out  1  combinational; equals cpu_req && state != CPU_RESP
- ext_req, ext_we, ext_addr, ext_wdata  in  1/1/NBits/NBits  same meaning for EXT
- ext_rdata  out  NBits  EXT load data
- ext_ack  out  1  one-cycle completion pulse
- mem_addr  out  NBits  word index to memory
- mem_wdata  out  NBits  write data
- mem_we, mem_re  out  1  memory strobes; memory writes synchronously and reads combinationally
- addr_err  out  1  one-cycle error pulse; tied 0 without the macro

## Operation
- States: IDLE, CPU_ACCESS, CPU_RESP, EXT_ACCESS, EXT_RESP.
- IDLE, no request: stay in IDLE.
- IDLE, any request: latch the winner's we/addr/wdata into access registers, then go to x_ACCESS.
- Winner selection: CPU wins ties, unless starve_cnt == STARVE_LIMIT, in which case EXT wins.
- x_ACCESS: drive mem_* from the latched registers. mem_we = latched we; mem_re = !latched we. Capture mem_rdata into x_rdata on reads. Next state x_RESP.
- CPU_RESP: cpu_stall drops and the pipeline advances. Next state IDLE. The still-high cpu_req is not re-arbitrated in this cycle.
- EXT_RESP: ext_ack = 1. Next state IDLE.
- Starvation counter (starve_cnt), width $clog2(STARVE_LIMIT+1):
  - Increments, saturating, when IDLE grants CPU while ext_req = 1.
  - Clears when EXT is granted or when ext_req = 0 in IDLE.
- Address translation: offset = addr − BASE_ADDR, modulo 2^NBits. mem_addr = offset >> 2. addr[1:0] is ignored.
- EXT must hold req and its fields until ext_ack. If EXT drops ext_req early, the latched transaction still completes.
- Reset mid-transaction: return to IDLE and abandon the transaction. No write occurs after reset asserts.
- Reset values:
  - state = IDLE, starve_cnt = 0
  - cpu_rdata = 0, ext_rdata = 0
  - ext_ack = 0, addr_err = 0
  - mem_addr = 0, mem_wdata = 0, mem_we = 0, mem_re = 0

## Timing
- Every access takes 3 cycles: arbitrate (N), ACCESS (N+1), RESP (N+2).
- Peak throughput is one access per 3 cycles.
- CPU request raised in cycle N with state IDLE:
  - cpu_stall = 1 in N and N+1, 0 in N+2.
  - cpu_rdata is valid from N+2.
- mem_we/mem_re are high only during the ACCESS cycle. All mem_* outputs are registered.
- ext_ack is high in cycle N+2 only.

## Configuration
- DMEM_ARB_ADDR_CHECK_EN defined:
  - An access is flagged when offset ≥ MEMORY_DEPTH*4 (this also covers addr < BASE_ADDR through wrap-around) or when addr[1:0] != 0.
  - For a flagged access: mem_we and mem_re stay 0 in ACCESS, x_rdata is loaded with 0, and addr_err pulses in RESP.
- Undefined: no checking; addresses wrap into memory; addr_err is constant 0.

## Structure
- Package dmem_arb_pkg holds:
  - the state enum
  - the BASE_ADDR default
  - a starve-counter width function
- Sub-module dmem_addr_xlate: combinational offset subtraction, word-index shift, and range/alignment flag when the macro is enabled.

## Test plan
- CPU read, addr 0x1001_0008, memory word 2 = 0xDEAD_BEEF → mem_addr = 2 and mem_re = 1 in N+1; cpu_rdata = 0xDEAD_BEEF and cpu_stall = 0 in N+2.
- CPU write 0x1234_5678 to 0x1001_0010 → mem_we = 1 for exactly one cycle with mem_addr = 4; a subsequent CPU read returns 0x1234_5678.
- cpu_req and ext_req held high continuously, STARVE_LIMIT = 4 → four CPU grants, then EXT granted; ext_ack pulses; starve_cnt = 0 afterwards.
- Reset asserted during CPU_ACCESS of a write → mem_we = 0 immediately; state = IDLE; the target word is unchanged.
- DMEM_ARB_ADDR_CHECK_EN, write to 0x1001_0100 with depth 64 → no mem_we; addr_err = 1 in RESP; EXT read of 0x1001_0002 → ext_rdata = 0 and addr_err = 1.
- Macro undefined, read of 0x1001_0100 → mem_addr = 64 (wraps in memory); addr_err stays 0.
